mvm_fifo_loader: RTL and testbench

Upstream feeder for the matrix-vector multiply datapath. On a start pulse it fetches ROWS+1 words from the memory wrapper over an Avalon-MM-style read port (rows 0..ROWS-1 are matrix A, word ROWS is vector B). It unpacks each word into LANES elements and pushes them, lane 0 first, into the matching per-row input FIFO of the MAC array, stalling on FIFO full. It pulses done when every FIFO has been loaded, which releases the MAC stage to execute.

---
 rtl/mvm_fifo_loader.sv | 153 +++++++++++++++
 tb/tb_mvm_fifo_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_fifo_loader.sv
// Loads matrix A rows and vector B from memory into the MAC array's per-row input FIFOs.
// Optional read-response watchdog: define MVM_LOADER_TIMEOUT_EN.
module mvm_fifo_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES = 8,
  parameter int ROWS = 8,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [ADDR_WIDTH-1:0]         mem_address,
  output logic                          mem_read,
  input  logic [DATA_WIDTH*LANES-1:0]   mem_readdata,
  input  logic                          mem_readdatavalid,
  input  logic                          mem_waitrequest,
  output logic [ROWS:0]                 fifo_wren,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  input  logic [ROWS:0]                 fifo_full
);

  localparam int IDX_W  = $clog2(ROWS + 1);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mvm_fifo_loader: TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, REQ, WAIT, PUSH, DONE} state_t;

  state_t                        state;
  logic [IDX_W-1:0]              idx;
  logic [IDX_W-1:0]              idx_next;
  logic [LANE_W-1:0]             lane;
  logic [DATA_WIDTH*LANES-1:0]   word;
  logic                          push_ok;

`ifdef MVM_LOADER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign idx_next = idx + IDX_W'(1);
  assign push_ok  = (state == PUSH) && !fifo_full[idx];

  // Only the FIFO of the current word is ever enabled; a full flag simply
  // withholds the write so the lane counter holds and nothing is lost.
  always_comb begin
    fifo_wren = '0;
    if (push_ok) fifo_wren[idx] = 1'b1;
  end

  always_comb begin
    fifo_wdata = '0;
    if (state == PUSH) fifo_wdata = word[int'(lane)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      lane        <= '0;
      word        <= '0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef MVM_LOADER_TIMEOUT_EN
      wait_cnt    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= REQ;
            idx         <= '0;
            lane        <= '0;
            busy        <= 1'b1;
            mem_read    <= 1'b1;
            mem_address <= BASE_ADDR;
`ifdef MVM_LOADER_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
          end
        end

        // Address and read stay registered until the memory lets go of waitrequest.
        REQ: begin
          if (!mem_waitrequest) begin
            mem_read <= 1'b0;
            state    <= WAIT;
`ifdef MVM_LOADER_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end

        WAIT: begin
          if (mem_readdatavalid) begin
            word  <= mem_readdata;
            lane  <= '0;
            state <= PUSH;
          end
`ifdef MVM_LOADER_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end

        PUSH: begin
          if (!fifo_full[idx]) begin
            if (lane == LANE_W'(LANES - 1)) begin
              lane <= '0;
              if (idx == IDX_W'(ROWS)) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                idx         <= idx_next;
                state       <= REQ;
                mem_read    <= 1'b1;
                mem_address <= BASE_ADDR + ADDR_WIDTH'(idx_next);
              end
            end else begin
              lane <= lane + LANE_W'(1);
            end
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_fifo_loader.sv
// Scoreboard bench for mvm_fifo_loader: memory model with latency 2, FIFO full and
// waitrequest injection, reset mid-load, and the watchdog when MVM_LOADER_TIMEOUT_EN is set.
module tb_mvm_fifo_loader;

  localparam int DW       = 8;
  localparam int LANES    = 8;
  localparam int ROWS     = 8;
  localparam int AW       = 32;
  localparam int W        = DW * LANES;
  localparam int LAT      = 2;
  localparam int LOAD_CYC = (ROWS + 1) * (1 + LAT + LANES);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, err;
  logic [AW-1:0] mem_address;
  logic          mem_read;
  logic [W-1:0]  mem_readdata = '0;
  logic          mem_readdatavalid = 1'b0;
  logic          mem_waitrequest = 1'b0;
  logic [ROWS:0] fifo_wren;
  logic [DW-1:0] fifo_wdata;
  logic [ROWS:0] fifo_full = '0;

  always #5 clk = ~clk;

  mvm_fifo_loader #(
    .DATA_WIDTH(DW), .LANES(LANES), .ROWS(ROWS), .ADDR_WIDTH(AW), .TIMEOUT(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .mem_address(mem_address), .mem_read(mem_read), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .mem_waitrequest(mem_waitrequest),
    .fifo_wren(fifo_wren), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full)
  );

  typedef struct { int row; logic [DW-1:0] data; } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] mem_words [ROWS+1];
  int tests_run = 0, failures = 0;
  int accepted = 0, cyc = 0, done_count = 0;
  int row_writes [ROWS+1];
  int w0_first = -1, w0_last = -1;
  int drop_addr = -1, stall_word = -1, stall_left = 0;
  int full_row = -1, full_after = 0, full_left = 0;
  int cd = 0, rsp = 0, mon_row = 0;
  bit acc = 1'b0, stalling = 1'b0;
  exp_t mon_e;
  int n, dc;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Memory, waitrequest and FIFO-full stimulus, all driven #1 after the clock edge.
  initial begin : mem_model
    forever begin
      @(negedge clk);
      acc = rst_n && mem_read && !mem_waitrequest;
      if (acc) begin
        checkOutput("read_address", mem_address, accepted);
        rsp = int'(mem_address);
        accepted++;
      end
      @(posedge clk);
      #1;
      mem_readdatavalid = 1'b0;
      if (!rst_n) cd = 0;
      if (cd > 0) begin
        cd--;
        if (cd == 0 && rsp != drop_addr) begin
          mem_readdatavalid = 1'b1;
          mem_readdata = mem_words[rsp];
        end
      end
      if (acc) cd = LAT - 1;
      mem_waitrequest = 1'b0;
      if (stall_left > 0 && (stalling || (mem_read && accepted == stall_word))) begin
        if (stalling) checkOutput("stall_read_held", mem_read, 1);
        checkOutput("stall_addr_held", mem_address, stall_word);
        stalling = 1'b1;
        mem_waitrequest = 1'b1;
        stall_left--;
      end else begin
        stalling = 1'b0;
      end
      fifo_full = '0;
      if (full_left > 0 && row_writes[full_row] >= full_after) begin
        fifo_full[full_row] = 1'b1;
        full_left--;
      end
    end
  end

  // Scoreboard monitor: every FIFO write is popped and compared.
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (done) done_count++;
      if (fifo_full != '0) checkOutput("wren_while_full", fifo_wren & fifo_full, 0);
      if (fifo_wren != '0) begin
        checkOutput("wren_onehot", $countones(fifo_wren), 1);
        mon_row = 0;
        for (int i = 0; i <= ROWS; i++) if (fifo_wren[i]) mon_row = i;
        checkOutput("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          checkOutput("fifo_row", mon_row, mon_e.row);
          checkOutput("fifo_data", fifo_wdata, mon_e.data);
        end
        row_writes[mon_row]++;
        if (mon_row == 0) begin
          if (w0_first < 0) w0_first = cyc;
          w0_last = cyc;
        end
      end
    end
  end

  task automatic applyStimulus();
    exp_t e;
    exp_q.delete();
    accepted = 0;
    foreach (row_writes[i]) row_writes[i] = 0;
    w0_first = -1;
    w0_last = -1;
    for (int k = 0; k <= ROWS; k++) begin
      for (int l = 0; l < LANES; l++) begin
        e.row = k;
        e.data = mem_words[k][l*DW +: DW];
        exp_q.push_back(e);
      end
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input bit spurious, output int cycles);
    cycles = 0;
    while (!done && cycles < LOAD_CYC + 100) begin
      start = spurious && (cycles == 20);
      if (cycles == 10) checkOutput("busy_mid_load", busy, 1);
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
    checkOutput("done_seen", done, 1);
    checkOutput("busy_at_done", busy, 0);
    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", done, 0);
    checkOutput("err_low", err, 0);
    checkOutput("queue_drained", exp_q.size(), 0);
    checkOutput("reads_accepted", accepted, ROWS + 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    foreach (row_writes[i]) row_writes[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_mem_read", mem_read, 0);
    checkOutput("rst_mem_address", mem_address, 0);
    checkOutput("rst_fifo_wren", fifo_wren, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Word k = {8{k+1}}; stray start while busy must be ignored.
    for (int k = 0; k <= ROWS; k++) mem_words[k] = {8{8'(k + 1)}};
    applyStimulus();
    waitDone(1'b1, n);
    checkOutput("latency_basic", n, 99);

    mem_words[0] = 64'h0706050403020100;
    applyStimulus();
    waitDone(1'b0, n);
    checkOutput("latency_word0", n, 99);
    checkOutput("row0_consecutive", w0_last - w0_first, 7);

    full_row = 3; full_after = 3; full_left = 5;
    applyStimulus();
    waitDone(1'b0, n);
    checkOutput("latency_full_stall", n, 104);
    checkOutput("full_applied", full_left, 0);

    stall_word = 5; stall_left = 4;
    applyStimulus();
    waitDone(1'b0, n);
    checkOutput("latency_waitrequest", n, 103);
    checkOutput("stall_applied", stall_left, 0);
    stall_word = -1;

    // Reset in the middle of row 2, then a clean reload.
    applyStimulus();
    n = 0;
    while (row_writes[2] < 3 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("reached_row2", row_writes[2] >= 3, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_mem_read", mem_read, 0);
    checkOutput("async_mem_address", mem_address, 0);
    checkOutput("async_fifo_wren", fifo_wren, 0);
    checkOutput("async_fifo_wdata", fifo_wdata, 0);
    checkOutput("async_busy", busy, 0);
    checkOutput("async_done", done, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus();
    waitDone(1'b1, n);
    checkOutput("latency_after_reset", n, 99);

`ifdef MVM_LOADER_TIMEOUT_EN
    drop_addr = 4;
    dc = done_count;
    applyStimulus();
    n = 0;
    while (!err && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("timeout_err", err, 1);
    checkOutput("timeout_latency", n, 55);
    checkOutput("timeout_busy", busy, 0);
    checkOutput("timeout_no_done", done_count, dc);
    checkOutput("timeout_rows_left", exp_q.size(), (ROWS + 1 - 4) * LANES);
    exp_q.delete();
    drop_addr = -1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("err_sticky", err, 1);
    applyStimulus();
    checkOutput("err_cleared_by_start", err, 0);
    waitDone(1'b0, n);
    checkOutput("latency_after_timeout", n, 99);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
